mem_arbiter: RTL and testbench

Parametrised N-channel arbiter and byte-serialiser in front of the 8-bit unified RAM bus. It generalises the current two-requester cache front end (instruction fetch plus LSB) to NUM_CH requesters. It adds a selectable fixed or round-robin priority, and a flush that aborts in-flight reads while letting in-flight writes finish. It sits between the fetch, LSB and IO-buffer clients and the top-level `mem_*` pins.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the unified-RAM front-end arbiter.
//   - SIZE_* : per-channel transfer size codes (code 3 behaves as a word)
//   - arb_state_e : arbiter FSM states
//   - size_to_bytes : size code -> byte count (1, 2 or 4)
package mem_arb_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational winner selection for mem_arbiter.
//   Ports:
//     req  [NUM_CH] : request vector
//     ptr  [PTR_W]  : index of the previous winner (round-robin mode only)
//     mode          : 0 = lowest index wins, 1 = scan upward from ptr+1 with wrap
//     gnt  [NUM_CH] : one-hot winner, all zero when no request is set
module rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] ch;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (mode) begin
        ch = PTR_W'((32'(ptr) + 32'd1 + i) % NUM_CH);
      end else begin
        ch = PTR_W'(i);
      end
      if (!found && req[ch]) begin
        gnt[ch] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   NUM_CH-channel arbiter and byte serialiser in front of the 8-bit
//   unified RAM bus. One transfer (1, 2 or 4 bytes, read or write) is
//   serviced at a time; the owner gets a one-cycle ready pulse at the end.
//   A flush aborts an in-flight read but lets an in-flight write finish.
//   Ports:
//     clk_in, rst_in (async, active low), rdy_in (global enable), flush
//     req/wr [NUM_CH], addr [NUM_CH*ADDR_W], wdata [NUM_CH*32],
//     size [NUM_CH*2]                 : per-channel request fields
//     ready [NUM_CH], rdata [32]      : completion pulse and read result
//     grant [NUM_CH]                  : one-hot owner while a transfer runs
//     mem_din, mem_dout, mem_a, mem_wr: RAM bus (mem_din lags mem_a by one cycle)
//   ADDR_W must not exceed 32; addresses are zero-extended onto mem_a.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        wr,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*32-1:0]     wdata,
  input  logic [NUM_CH*2-1:0]      size,
  output logic [NUM_CH-1:0]        ready,
  output logic [31:0]              rdata,
  output logic [NUM_CH-1:0]        grant,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_e state_q, state_d;

  logic [NUM_CH-1:0] win_oh;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  ptr_q;
  logic [NUM_CH-1:0] owner_q;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_size;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] result_q;
  logic [2:0]  n_q;
  logic [2:0]  idx_q;
  logic [1:0]  cap_sel;
  logic        start;

  // Winner selection
  rr_arbiter #(
    .NUM_CH(NUM_CH),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .mode(RR_MODE != 0),
    .gnt (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
  end

  // One-hot mux of the winning channel's request fields
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win_oh[i]) begin
        sel_wr    = wr[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*32 +: 32];
        sel_size  = size[i*2 +: 2];
      end
    end
  end

  assign start   = (state_q == IDLE) && !flush && (|req);
  // Read byte k arrives while idx = k+1, one cycle after its address.
  assign cap_sel = 2'(idx_q - 3'd1);

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next state and bus/handshake outputs (Moore, so rdy_in low holds them)
  always_comb begin
    state_d  = state_q;
    grant    = '0;
    ready    = '0;
    rdata    = '0;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        grant = owner_q;
        if (wr_q) begin
          // Writes ignore flush: a started store always completes.
          mem_a    = addr_q + 32'(idx_q);
          mem_wr   = 1'b1;
          mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
          if (idx_q == n_q - 3'd1) state_d = DONE;
        end else begin
          // Extra cycle at idx = n only collects the last returned byte.
          if (idx_q < n_q) mem_a = addr_q + 32'(idx_q);
          if (flush) begin
            state_d = IDLE;
          end else if (idx_q == n_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // No grant here, so a req still high during its own ready is not re-served.
        ready   = owner_q;
        rdata   = wr_q ? 32'd0 : result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched request, byte index, read assembly and round-robin pointer
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      owner_q  <= '0;
      ptr_q    <= PTR_W'(NUM_CH - 1);
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            owner_q  <= win_oh;
            wr_q     <= sel_wr;
            addr_q   <= 32'(sel_addr);
            wdata_q  <= sel_wdata;
            n_q      <= size_to_bytes(sel_size);
            idx_q    <= '0;
            result_q <= '0;
            if (RR_MODE != 0) ptr_q <= win_idx;
          end
        end
        RUN: begin
          idx_q <= idx_q + 3'd1;
          if (!wr_q && idx_q != 3'd0) begin
            result_q[{cap_sel, 3'b000} +: 8] <= mem_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned NCH = 3;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              rdy_in = 1'b1;
  logic              flush  = 1'b0;
  logic [NCH-1:0]    req    = '0;
  logic [NCH-1:0]    wr     = '0;
  logic [NCH*32-1:0] addr   = '0;
  logic [NCH*32-1:0] wdata  = '0;
  logic [NCH*2-1:0]  size   = '0;

  logic [NCH-1:0] ready, grant;
  logic [31:0]    rdata, mem_a;
  logic [7:0]     mem_din, mem_dout;
  logic           mem_wr;

  logic [NCH-1:0] fp_ready, fp_grant;
  logic [31:0]    fp_rdata, fp_mem_a;
  logic [7:0]     fp_mem_dout;
  logic           fp_mem_wr;

  mem_arbiter #(.NUM_CH(NCH), .RR_MODE(1), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .req(req), .wr(wr), .addr(addr), .wdata(wdata), .size(size),
    .ready(ready), .rdata(rdata), .grant(grant),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  mem_arbiter #(.NUM_CH(NCH), .RR_MODE(0), .ADDR_W(32)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .req(req), .wr(wr), .addr(addr), .wdata(wdata), .size(size),
    .ready(fp_ready), .rdata(fp_rdata), .grant(fp_grant),
    .mem_din(8'h00), .mem_dout(fp_mem_dout), .mem_a(fp_mem_a), .mem_wr(fp_mem_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: 4 KiB window, one-cycle read latency, gated by rdy_in
  logic [7:0] ram   [0:4095];
  bit         ram_v [0:4095];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_v[a[11:0]]) return ram[a[11:0]];
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) begin
        ram[mem_a[11:0]]   <= mem_dout;
        ram_v[mem_a[11:0]] <= 1'b1;
      end
      mem_din <= ram_rd(mem_a);
    end
  end

  typedef struct {
    int          ch;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [NCH-1:0] oh;
    logic [31:0]    rd;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  logic [NCH-1:0] fp_log[$];
  vec_t           vecs[9];
  int             n_tests = 0;
  int             n_fail  = 0;

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int ch, input logic [31:0] rd, input int at);
    exp_t e;
    e.oh  = NCH'(1 << ch);
    e.rd  = rd;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int ch, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (ready[ch]) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: ready[%0d] got no pulse in %0d cycles, expected one", ch, budget);
    end
  endtask

  task automatic set_ch(input int ch, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
    wr[ch]           = w;
    addr[ch*32 +: 32] = a;
    wdata[ch*32 +: 32] = d;
    size[ch*2 +: 2]   = sz;
  endtask

  // Scoreboard consumer: every ready pulse must match the oldest expectation
  task automatic monitor();
    exp_t           e;
    logic [NCH-1:0] fp_prev;
    fp_prev = '0;
    forever begin
      @(negedge clk_in);
      if (fp_grant != '0 && fp_prev == '0) fp_log.push_back(fp_grant);
      fp_prev = fp_grant;
      if (rst_in) begin
        chk("ready_onehot0", 32'($onehot0(ready)), 32'd1);
        if (ready != '0) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=%b, expected none", ready);
          end else begin
            e = sb.pop_front();
            chk("ready_vec", 32'(ready), 32'(e.oh));
            chk("rdata", rdata, e.rd);
            chk("ready_cycle", cyc, e.cyc);
          end
        end else begin
          chk("rdata_idle", rdata, 32'd0);
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int             k;
    int             n;
    logic [NCH-1:0] oh;
    @(posedge clk_in); #1;
    k  = cyc;
    n  = nbytes(v.sz);
    oh = NCH'(1 << v.ch);
    set_ch(v.ch, v.w, v.a, v.d, v.sz);
    req[v.ch] = 1'b1;
    push_exp(v.ch, v.exp_rd, k + n + (v.w ? 1 : 2));
    @(negedge clk_in);
    chk("grant_idle", 32'(grant), 32'd0);
    for (int j = 0; j < n; j++) begin
      @(negedge clk_in);
      chk("bus_addr", mem_a, v.a + 32'(j));
      chk("bus_wr", 32'(mem_wr), 32'(v.w));
      chk("grant_run", 32'(grant), 32'(oh));
      if (v.w) chk("bus_dout", 32'(mem_dout), 32'(8'(v.d >> (8*j))));
    end
    if (!v.w) begin
      @(negedge clk_in);
      chk("bus_capture_addr", mem_a, 32'd0);
    end
    wait_ready(v.ch, 8);
    req[v.ch] = 1'b0;
    if (v.w) begin
      for (int j = 0; j < n; j++) begin
        chk("ram_byte", 32'(ram_rd(v.a + 32'(j))), 32'(8'(v.d >> (8*j))));
      end
    end
  endtask

  initial begin
    int k;

    fork
      monitor();
    join_none

    vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         2'd2, 32'h4433_2211};
    vecs[1] = '{1, 1'b1, 32'h0000_01FF, 32'h0000_ABCD, 2'd1, 32'h0};
    vecs[2] = '{1, 1'b0, 32'h0000_01FF, 32'h0,         2'd1, 32'h0000_ABCD};
    vecs[3] = '{2, 1'b0, 32'h0000_0102, 32'h0,         2'd0, 32'h0000_0033};
    vecs[4] = '{0, 1'b1, 32'hFFFF_FFFE, 32'h1234_5678, 2'd3, 32'h0};
    vecs[5] = '{2, 1'b0, 32'hFFFF_FFFE, 32'h0,         2'd2, 32'h1234_5678};
    vecs[6] = '{0, 1'b0, 32'h0000_0101, 32'h0,         2'd1, 32'h0000_3322};
    vecs[7] = '{2, 1'b1, 32'h0000_0500, 32'hFFFF_FF7E, 2'd0, 32'h0};
    vecs[8] = '{1, 1'b0, 32'h0000_04FF, 32'h0,         2'd2, 32'h0000_7E00};

    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted in the middle of a read
    @(posedge clk_in); #1;
    set_ch(0, 1'b0, 32'h0000_1000, 32'h0, 2'd2);
    req[0] = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    chk("midrd_addr", mem_a, 32'h0000_1001);
    chk("midrd_grant", 32'(grant), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    chk("arst_mem_wr", 32'(mem_wr), 32'd0);
    req[0] = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("post_rst_grant", 32'(grant), 32'd0);
    @(negedge clk_in);
    chk("post_rst_idle_a", mem_a, 32'd0);

    // Round-robin order with all requests held; fixed-priority twin alongside
    @(posedge clk_in); #1;
    fp_log.delete();
    k = cyc;
    set_ch(0, 1'b0, 32'h100, 32'h0, 2'd0);
    set_ch(1, 1'b0, 32'h101, 32'h0, 2'd0);
    set_ch(2, 1'b0, 32'h102, 32'h0, 2'd0);
    req = 3'b111;
    push_exp(0, 32'h11, k + 3);
    push_exp(1, 32'h22, k + 7);
    push_exp(2, 32'h33, k + 11);
    push_exp(0, 32'h11, k + 15);
    wait_ready(0, 8);
    wait_ready(1, 8);
    wait_ready(2, 8);
    wait_ready(0, 8);
    req = '0;
    @(negedge clk_in);
    chk("fp_grant_count", 32'(fp_log.size()), 32'd4);
    for (int i = 0; i < 3 && i < fp_log.size(); i++) begin
      chk("fp_grant_order", 32'(fp_log[i]), 32'd1);
    end

    // Flush during the second RUN cycle of a read
    @(posedge clk_in); #1;
    k = cyc;
    set_ch(0, 1'b0, 32'h100, 32'h0, 2'd2);
    req[0] = 1'b1;
    @(posedge clk_in); #1;
    set_ch(1, 1'b0, 32'h103, 32'h0, 2'd0);
    req[1] = 1'b1;
    push_exp(1, 32'h44, k + 6);
    @(posedge clk_in); #1;
    flush  = 1'b1;
    req[0] = 1'b0;
    @(posedge clk_in); #1;
    flush = 1'b0;
    @(negedge clk_in);
    chk("flush_rd_grant", 32'(grant), 32'd0);
    chk("flush_rd_mem_a", mem_a, 32'd0);
    @(negedge clk_in);
    chk("flush_next_grant", 32'(grant), 32'b010);
    wait_ready(1, 8);
    req[1] = 1'b0;

    // Flush during a word write must not cut it short
    @(posedge clk_in); #1;
    k = cyc;
    set_ch(2, 1'b1, 32'h300, 32'hDEAD_BEEF, 2'd2);
    req[2] = 1'b1;
    push_exp(2, 32'h0, k + 5);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    flush = 1'b1;
    @(posedge clk_in); #1;
    flush = 1'b0;
    wait_ready(2, 8);
    req[2] = 1'b0;
    chk("flush_wr_b0", 32'(ram_rd(32'h300)), 32'hEF);
    chk("flush_wr_b1", 32'(ram_rd(32'h301)), 32'hBE);
    chk("flush_wr_b2", 32'(ram_rd(32'h302)), 32'hAD);
    chk("flush_wr_b3", 32'(ram_rd(32'h303)), 32'hDE);

    // rdy_in low for three cycles in the middle of a word read
    @(posedge clk_in); #1;
    k = cyc;
    set_ch(0, 1'b0, 32'h100, 32'h0, 2'd2);
    req[0] = 1'b1;
    push_exp(0, 32'h4433_2211, k + 9);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    chk("stall_addr0", mem_a, 32'h101);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in); #1;
      chk("stall_addr_hold", mem_a, 32'h101);
      chk("stall_grant_hold", 32'(grant), 32'd1);
    end
    @(posedge clk_in); #1;
    rdy_in = 1'b1;
    wait_ready(0, 14);
    req[0] = 1'b0;

    repeat (3) @(posedge clk_in);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
